// File: rtl/intc_resp.sv
// Interrupt responder: captures timer/external request edges, arbitrates, raises irq_req/irq_cause and acks on trap.
// Optional macro INTC_SYNC_EN inserts a 2-flop synchronizer on each request input ahead of edge capture.
module intc_resp #(
  parameter int TIMER_CAUSE = 7,
  parameter int EXT_CAUSE   = 11,
  parameter int ACK_WIDTH   = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        timer_int,
  input  logic        external_int,
  input  logic        mie_glb,
  input  logic        mtie,
  input  logic        meie,
  input  logic        trap_taken,
  input  logic        mret,
  output logic        irq_req,
  output logic [31:0] irq_cause,
  output logic        timer_int_ack,
  output logic        ext_int_ack,
  output logic        in_handler
);

  localparam logic [3:0] TIMER_C4 = 4'(TIMER_CAUSE);
  localparam logic [3:0] EXT_C4   = 4'(EXT_CAUSE);
  localparam logic [3:0] ACK_W4   = 4'(ACK_WIDTH);

  typedef enum logic [1:0] {IDLE, REQ, ACK, HANDLER} state_e;

  state_e      state_q, state_d;
  logic [1:0]  src;          // bit 0 = timer, bit 1 = external
  logic [1:0]  prev_q, prev_d;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  rise, clr;
  logic        sel_q, sel_d;  // 0 = timer, 1 = external
  logic [31:0] cause_q, cause_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mret_seen_q, mret_seen_d;
  logic        elig_t, elig_e, sel_en;

`ifdef INTC_SYNC_EN
  logic [1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {external_int, timer_int};
      sync2_q <= sync1_q;
    end
  end

  assign src = sync2_q;
`else
  assign src = {external_int, timer_int};
`endif

  always_comb begin
    rise        = src & ~prev_q;
    prev_d      = src;
    elig_t      = mie_glb & mtie & pend_q[0];
    elig_e      = mie_glb & meie & pend_q[1];
    sel_en      = sel_q ? meie : mtie;
    state_d     = state_q;
    sel_d       = sel_q;
    cause_d     = cause_q;
    cnt_d       = cnt_q;
    mret_seen_d = mret_seen_q;
    clr         = 2'b00;

    case (state_q)
      IDLE: begin
        mret_seen_d = 1'b0;
        if (elig_t | elig_e) begin
          sel_d   = elig_e;
          cause_d = {1'b1, 27'b0, (elig_e ? EXT_C4 : TIMER_C4)};
          state_d = REQ;
        end
      end
      REQ: begin
        // trap_taken outranks a same-cycle enable drop
        if (trap_taken) begin
          clr         = sel_q ? 2'b10 : 2'b01;
          cnt_d       = ACK_W4;
          mret_seen_d = 1'b0;
          state_d     = ACK;
        end else if (!mie_glb || !sel_en) begin
          state_d = IDLE;
        end
      end
      ACK: begin
        if (mret) mret_seen_d = 1'b1;
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = (mret_seen_q | mret) ? IDLE : HANDLER;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HANDLER: begin
        if (mret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // a new edge in the same cycle as the clear keeps the request pending
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      prev_q      <= 2'b00;
      pend_q      <= 2'b00;
      sel_q       <= 1'b0;
      cause_q     <= 32'd0;
      cnt_q       <= 4'd0;
      mret_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      pend_q      <= pend_d;
      sel_q       <= sel_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
      mret_seen_q <= mret_seen_d;
    end
  end

  assign irq_req       = (state_q == REQ);
  assign irq_cause     = cause_q;
  assign timer_int_ack = (state_q == ACK) && !sel_q;
  assign ext_int_ack   = (state_q == ACK) && sel_q;
  assign in_handler    = (state_q == ACK) || (state_q == HANDLER);

endmodule

// File: tb/tb_intc_resp.sv
// Bench for intc_resp: directed cycle table, hand-written corner sequences, and random stimulus against a reference model.
module tb_intc_resp;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic t_in = 1'b0, e_in = 1'b0, mie = 1'b0, mtie = 1'b0, meie = 1'b0, trap = 1'b0, mret_in = 1'b0;

  logic        o_req[2];
  logic [31:0] o_cause[2];
  logic        o_tack[2], o_eack[2], o_inh[2];

  int checks = 0;
  int failures = 0;

`ifdef INTC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  intc_resp #(.ACK_WIDTH(1)) dut1 (
    .clk(clk), .rstn(rstn), .timer_int(t_in), .external_int(e_in),
    .mie_glb(mie), .mtie(mtie), .meie(meie), .trap_taken(trap), .mret(mret_in),
    .irq_req(o_req[0]), .irq_cause(o_cause[0]), .timer_int_ack(o_tack[0]),
    .ext_int_ack(o_eack[0]), .in_handler(o_inh[0])
  );

  intc_resp #(.ACK_WIDTH(3)) dut3 (
    .clk(clk), .rstn(rstn), .timer_int(t_in), .external_int(e_in),
    .mie_glb(mie), .mtie(mtie), .meie(meie), .trap_taken(trap), .mret(mret_in),
    .irq_req(o_req[1]), .irq_cause(o_cause[1]), .timer_int_ack(o_tack[1]),
    .ext_int_ack(o_eack[1]), .in_handler(o_inh[1])
  );

  always #5 clk = ~clk;

  // Reference model: one set of state per instance (0: 1-cycle ack, 1: 3-cycle ack)
  bit [1:0]  m_pend[2], m_prev[2];
  bit [1:0]  m_s1, m_s2;
  bit        m_req[2], m_sel[2], m_busy[2], m_early[2];
  int        m_left[2];
  bit [31:0] m_cause[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_prev[i] = 0; m_req[i] = 0; m_sel[i] = 0;
      m_busy[i] = 0; m_early[i] = 0; m_left[i] = 0; m_cause[i] = 0;
    end
    m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_step();
    bit [1:0] raw, src, edg, clr;
    bit el_e, el_t;
    int w;
    raw = {e_in, t_in};
`ifdef INTC_SYNC_EN
    src = m_s2; m_s2 = m_s1; m_s1 = raw;
`else
    src = raw;
`endif
    for (int i = 0; i < 2; i++) begin
      w    = (i == 0) ? 1 : 3;
      edg  = src & ~m_prev[i];
      clr  = 2'b00;
      el_e = mie && meie && m_pend[i][1];
      el_t = mie && mtie && m_pend[i][0];
      if (m_req[i]) begin
        if (trap) begin
          clr = m_sel[i] ? 2'b10 : 2'b01;
          m_req[i] = 0; m_left[i] = w; m_busy[i] = 1; m_early[i] = 0;
        end else if (!mie || !(m_sel[i] ? meie : mtie)) begin
          m_req[i] = 0;
        end
      end else if (m_left[i] > 0) begin
        if (mret_in) m_early[i] = 1;
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0 && m_early[i]) begin
          m_busy[i] = 0; m_early[i] = 0;
        end
      end else if (m_busy[i]) begin
        if (mret_in) m_busy[i] = 0;
      end else if (el_e || el_t) begin
        m_req[i]   = 1;
        m_sel[i]   = el_e;
        m_cause[i] = el_e ? 32'h8000000B : 32'h80000007;
      end
      m_pend[i] = (m_pend[i] & ~clr) | edg;
      m_prev[i] = src;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input int i);
    chk($sformatf("req%0d", i),   32'(o_req[i]),  32'(m_req[i]));
    chk($sformatf("cause%0d", i), o_cause[i],     m_cause[i]);
    chk($sformatf("tack%0d", i),  32'(o_tack[i]), 32'((m_left[i] > 0) && !m_sel[i]));
    chk($sformatf("eack%0d", i),  32'(o_eack[i]), 32'((m_left[i] > 0) && m_sel[i]));
    chk($sformatf("inh%0d", i),   32'(o_inh[i]),  32'(m_busy[i]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    bit t, e, mie, trap, mret;
    bit req; bit [3:0] cl; bit tack, eack, inh;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // t, e, mie, trap, mret | req, cause low bits (0 = cause still 0), tack, eack, inh
    tbl[0]  = '{1,1,1,0,0, 0,4'h0,0,0,0};
    tbl[1]  = '{1,1,1,0,0, 1,4'hB,0,0,0};
    tbl[2]  = '{1,1,1,0,0, 1,4'hB,0,0,0};
    tbl[3]  = '{1,1,1,1,0, 0,4'hB,0,1,1};
    tbl[4]  = '{1,1,1,0,0, 0,4'hB,0,0,1};
    tbl[5]  = '{1,1,1,0,1, 0,4'hB,0,0,0};
    tbl[6]  = '{1,1,1,0,0, 1,4'h7,0,0,0};
    tbl[7]  = '{1,1,1,1,0, 0,4'h7,1,0,1};
    tbl[8]  = '{1,1,1,0,0, 0,4'h7,0,0,1};
    tbl[9]  = '{1,1,1,0,1, 0,4'h7,0,0,0};
    tbl[10] = '{0,0,1,0,0, 0,4'h7,0,0,0};
    tbl[11] = '{1,0,1,0,0, 0,4'h7,0,0,0};
    tbl[12] = '{1,0,1,0,0, 1,4'h7,0,0,0};
    tbl[13] = '{1,0,0,0,0, 0,4'h7,0,0,0};
    tbl[14] = '{1,0,1,0,0, 1,4'h7,0,0,0};
    tbl[15] = '{1,0,1,1,0, 0,4'h7,1,0,1};
    tbl[16] = '{1,0,1,0,0, 0,4'h7,0,0,1};
    tbl[17] = '{1,0,1,0,1, 0,4'h7,0,0,0};
    tbl[18] = '{1,0,1,0,0, 0,4'h7,0,0,0};

    model_reset();
    mie = 1; mtie = 1; meie = 1;
    do_reset();

    // reset state, both instances
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_req%0d", i),   32'(o_req[i]),  32'd0);
      chk($sformatf("rst_cause%0d", i), o_cause[i],     32'd0);
      chk($sformatf("rst_tack%0d", i),  32'(o_tack[i]), 32'd0);
      chk($sformatf("rst_eack%0d", i),  32'(o_eack[i]), 32'd0);
      chk($sformatf("rst_inh%0d", i),   32'(o_inh[i]),  32'd0);
    end

    // edge-to-request latency
    repeat (3) tick();
    t_in = 1;
    repeat (LAT - 1) tick();
    chk("lat_early_req", 32'(o_req[0]), 32'd0);
    tick();
    chk("lat_req", 32'(o_req[0]), 32'd1);
    chk("lat_cause", o_cause[0], 32'h80000007);
    t_in = 0;

`ifndef INTC_SYNC_EN
    // cycle table on the 1-cycle-ack instance
    do_reset();
    for (int k = 0; k < 19; k++) begin
      t_in = tbl[k].t; e_in = tbl[k].e; mie = tbl[k].mie; trap = tbl[k].trap; mret_in = tbl[k].mret;
      tick();
      chk($sformatf("tbl%0d_req", k),   32'(o_req[0]), 32'(tbl[k].req));
      chk($sformatf("tbl%0d_cause", k), o_cause[0], (tbl[k].cl == 0) ? 32'd0 : {1'b1, 27'b0, tbl[k].cl});
      chk($sformatf("tbl%0d_tack", k),  32'(o_tack[0]), 32'(tbl[k].tack));
      chk($sformatf("tbl%0d_eack", k),  32'(o_eack[0]), 32'(tbl[k].eack));
      chk($sformatf("tbl%0d_inh", k),   32'(o_inh[0]),  32'(tbl[k].inh));
    end
    t_in = 0; e_in = 0; trap = 0; mret_in = 0; mie = 1;

    // 3-cycle ext ack with an mret arriving mid-ack
    do_reset();
    e_in = 1;
    tick(); tick();
    chk("w3_req", 32'(o_req[1]), 32'd1);
    chk("w3_cause", o_cause[1], 32'h8000000B);
    trap = 1; tick(); trap = 0;
    chk("w3_eack_m1", 32'(o_eack[1]), 32'd1);
    tick();
    chk("w3_eack_m2", 32'(o_eack[1]), 32'd1);
    mret_in = 1; tick(); mret_in = 0;
    chk("w3_eack_m3", 32'(o_eack[1]), 32'd1);
    chk("w3_inh_m3", 32'(o_inh[1]), 32'd1);
    chk("w3_tack_m3", 32'(o_tack[1]), 32'd0);
    tick();
    chk("w3_eack_m4", 32'(o_eack[1]), 32'd0);
    chk("w3_inh_m4", 32'(o_inh[1]), 32'd0);
    chk("w3_req_m4", 32'(o_req[1]), 32'd0);
    tick();
    chk("w3_no_repend", 32'(o_req[1]), 32'd0);
    e_in = 0;

    // reset mid-ack with the timer level held high
    do_reset();
    t_in = 1;
    tick(); tick();
    trap = 1; tick(); trap = 0;
    chk("rsta_tack_before", 32'(o_tack[1]), 32'd1);
    rstn = 0; model_reset();
    #1;
    chk("rsta_tack0", 32'(o_tack[0]), 32'd0);
    chk("rsta_tack1", 32'(o_tack[1]), 32'd0);
    chk("rsta_inh1", 32'(o_inh[1]), 32'd0);
    @(negedge clk);
    rstn = 1;
    tick();
    chk("rsta_req_early", 32'(o_req[1]), 32'd0);
    tick();
    chk("rsta_req", 32'(o_req[1]), 32'd1);
    chk("rsta_cause", o_cause[1], 32'h80000007);
    t_in = 0;
`endif

    // random stimulus against the model, both instances
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) t_in = ~t_in;
      if ($urandom_range(0, 15) == 0) e_in = ~e_in;
      mie     = ($urandom_range(0, 15) != 0);
      mtie    = ($urandom_range(0, 7) != 0);
      meie    = ($urandom_range(0, 7) != 0);
      trap    = ($urandom_range(0, 2) == 0);
      mret_in = ($urandom_range(0, 5) == 0);
      tick();
      cmp_model(0);
      cmp_model(1);
      if ($urandom_range(0, 299) == 0) begin
        rstn = 0;
        model_reset();
        #1;
        cmp_model(0);
        cmp_model(1);
        @(negedge clk);
        rstn = 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
